// File: rtl/load_store_unit.sv
// ============================================================================
// load_store_unit
// ----------------------------------------------------------------------------
// Purpose:
//    Sits between the pipeline and a word-wide data memory. It takes one
//    load or store request at a time, aligns sub-word accesses onto
//    little-endian byte lanes and sign/zero-extends load results. Byte and
//    halfword stores use a read-modify-write sequence so that the
//    neighbouring lanes of the memory word are preserved.
//    Misaligned or illegal requests complete in one cycle with an error
//    pulse and never touch memory.
//
// Ports:
//    clk               single clock, rising edge
//    reset             asynchronous, active-high reset
//    req_valid_i       request present (sampled only in IDLE)
//    req_write_i       1 = store, 0 = load
//    req_size_i        00 byte, 01 halfword, 10 word, 11 illegal
//    req_unsigned_i    1 = zero-extend loads, 0 = sign-extend loads
//    req_address_i     byte address
//    req_store_data_i  store data, sub-word data in the low bits
//    ready_o           high only in IDLE
//    done_o            one-cycle completion pulse
//    error_o           one-cycle pulse with done_o for misaligned/illegal
//    load_data_o       extended load result, held until the next load
//    mem_address_o     word-aligned memory address
//    mem_write_data_o  word written to memory (0 when not writing)
//    mem_write_o       memory write strobe
//    mem_read_o        memory read strobe
//    mem_read_data_i   combinational memory read data
// ============================================================================
module load_store_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid_i,
   input  logic                  req_write_i,
   input  logic [1:0]            req_size_i,
   input  logic                  req_unsigned_i,
   input  logic [DATA_WIDTH-1:0] req_address_i,
   input  logic [DATA_WIDTH-1:0] req_store_data_i,
   output logic                  ready_o,
   output logic                  done_o,
   output logic                  error_o,
   output logic [DATA_WIDTH-1:0] load_data_o,
   output logic [DATA_WIDTH-1:0] mem_address_o,
   output logic [DATA_WIDTH-1:0] mem_write_data_o,
   output logic                  mem_write_o,
   output logic                  mem_read_o,
   input  logic [DATA_WIDTH-1:0] mem_read_data_i
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WRITE,
      RMW_READ,
      RMW_WRITE,
      DONE
   } state_e;

   state_e                state_q, state_d;
   logic                  write_q, write_d;
   logic [1:0]            size_q, size_d;
   logic                  unsigned_q, unsigned_d;
   logic [1:0]            offset_q, offset_d;
   logic [DATA_WIDTH-1:0] store_data_q, store_data_d;
   logic [DATA_WIDTH-1:0] address_q, address_d;
   logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
   logic [DATA_WIDTH-1:0] merge_q, merge_d;
   logic                  error_q, error_d;

   logic                  misaligned;
   logic [7:0]            load_byte;
   logic [15:0]           load_half;
   logic [DATA_WIDTH-1:0] load_ext;
   logic [DATA_WIDTH-1:0] merged_word;

   // A request is rejected when its size is illegal or when the address is
   // not a multiple of the access size. Bytes are always aligned.
   always_comb begin
      misaligned = 1'b0;
      case (req_size_i)
         2'b01:   misaligned = req_address_i[0];
         2'b10:   misaligned = (req_address_i[1:0] != 2'b00);
         2'b11:   misaligned = 1'b1;
         default: misaligned = 1'b0;
      endcase
   end

   // Pick the addressed lane out of the memory word and extend it. The
   // extension bit is the lane MSB gated off for unsigned loads.
   always_comb begin
      load_byte = mem_read_data_i[7:0];
      case (offset_q)
         2'd1:    load_byte = mem_read_data_i[15:8];
         2'd2:    load_byte = mem_read_data_i[23:16];
         2'd3:    load_byte = mem_read_data_i[31:24];
         default: load_byte = mem_read_data_i[7:0];
      endcase
      load_half = offset_q[1] ? mem_read_data_i[31:16] : mem_read_data_i[15:0];
      case (size_q)
         2'b00:   load_ext = {{24{load_byte[7] & ~unsigned_q}}, load_byte};
         2'b01:   load_ext = {{16{load_half[15] & ~unsigned_q}}, load_half};
         default: load_ext = mem_read_data_i;
      endcase
   end

   // Read-modify-write merge: the word captured during RMW_READ with only
   // the addressed lane overwritten by the low store bits.
   always_comb begin
      merged_word = merge_q;
      case (size_q)
         2'b00: begin
            case (offset_q)
               2'd0:    merged_word[7:0]   = store_data_q[7:0];
               2'd1:    merged_word[15:8]  = store_data_q[7:0];
               2'd2:    merged_word[23:16] = store_data_q[7:0];
               default: merged_word[31:24] = store_data_q[7:0];
            endcase
         end
         2'b01: begin
            if (offset_q[1]) begin
               merged_word[31:16] = store_data_q[15:0];
            end else begin
               merged_word[15:0] = store_data_q[15:0];
            end
         end
         default: merged_word = merge_q;
      endcase
   end

   // Next-state and next-register logic. Every register holds by default;
   // only acceptance in IDLE, the load capture and the RMW read capture
   // change the datapath registers.
   always_comb begin
      state_d      = state_q;
      write_d      = write_q;
      size_d       = size_q;
      unsigned_d   = unsigned_q;
      offset_d     = offset_q;
      store_data_d = store_data_q;
      address_d    = address_q;
      load_data_d  = load_data_q;
      merge_d      = merge_q;
      error_d      = error_q;
      case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               write_d      = req_write_i;
               size_d       = req_size_i;
               unsigned_d   = req_unsigned_i;
               offset_d     = req_address_i[1:0];
               store_data_d = req_store_data_i;
               address_d    = {req_address_i[DATA_WIDTH-1:2], 2'b00};
               error_d      = misaligned;
               if (misaligned) begin
                  state_d = DONE;
               end else if (!req_write_i) begin
                  state_d = LOAD;
               end else if (req_size_i == 2'b10) begin
                  state_d = WRITE;
               end else begin
                  state_d = RMW_READ;
               end
            end
         end
         LOAD: begin
            if (!write_q) begin
               load_data_d = load_ext;
            end
            state_d = DONE;
         end
         WRITE: begin
            state_d = DONE;
         end
         RMW_READ: begin
            merge_d = mem_read_data_i;
            state_d = RMW_WRITE;
         end
         RMW_WRITE: begin
            state_d = DONE;
         end
         DONE: begin
            error_d = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // All state lives here. Reset clears the datapath so the memory-facing
   // outputs read as zero straight away and any in-flight operation is
   // dropped without a write or a completion pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         write_q      <= 1'b0;
         size_q       <= 2'b00;
         unsigned_q   <= 1'b0;
         offset_q     <= 2'b00;
         store_data_q <= '0;
         address_q    <= '0;
         load_data_q  <= '0;
         merge_q      <= '0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         write_q      <= write_d;
         size_q       <= size_d;
         unsigned_q   <= unsigned_d;
         offset_q     <= offset_d;
         store_data_q <= store_data_d;
         address_q    <= address_d;
         load_data_q  <= load_data_d;
         merge_q      <= merge_d;
         error_q      <= error_d;
      end
   end

   // Strobes and handshakes are pure decodes of the state register, so the
   // two memory strobes can never be high together.
   assign ready_o       = (state_q == IDLE);
   assign done_o        = (state_q == DONE);
   assign error_o       = (state_q == DONE) && error_q;
   assign mem_read_o    = (state_q == LOAD) || (state_q == RMW_READ);
   assign mem_write_o   = (state_q == WRITE) || (state_q == RMW_WRITE);
   assign mem_address_o = address_q;
   assign load_data_o   = load_data_q;

   // Write data is only driven while a write strobe is up.
   always_comb begin
      case (state_q)
         WRITE:     mem_write_data_o = store_data_q;
         RMW_WRITE: mem_write_data_o = merged_word;
         default:   mem_write_data_o = '0;
      endcase
   end

endmodule

// File: tb/tb_load_store_unit.sv
// ============================================================================
// tb_load_store_unit
// ----------------------------------------------------------------------------
// Self-checking bench for load_store_unit. A 64-word memory model answers
// the DUT's reads combinationally and commits its writes on the clock. A
// separate reference copy of memory plus arithmetic lane helpers predict
// every result. Directed scenarios cover the worked examples; a randomized
// loop covers the rest. Inputs change and outputs are sampled on the
// falling edge.
// ============================================================================
module tb_load_store_unit;

   logic        clk;
   logic        reset;
   logic        reqValid;
   logic        reqWrite;
   logic [1:0]  reqSize;
   logic        reqUnsigned;
   logic [31:0] reqAddress;
   logic [31:0] reqStoreData;
   logic        readyO;
   logic        doneO;
   logic        errorO;
   logic [31:0] loadDataO;
   logic [31:0] memAddress;
   logic [31:0] memWriteData;
   logic        memWrite;
   logic        memRead;
   logic [31:0] memReadData;

   logic [31:0] mem    [0:63];
   logic [31:0] refMem [0:63];
   logic        tbWrEn;
   logic [5:0]  tbWrIdx;
   logic [31:0] tbWrData;

   logic [31:0] expLoadData;
   int          assertCount = 0;
   int          failCount   = 0;

   load_store_unit #(.DATA_WIDTH(32)) dut (
      .clk              (clk),
      .reset            (reset),
      .req_valid_i      (reqValid),
      .req_write_i      (reqWrite),
      .req_size_i       (reqSize),
      .req_unsigned_i   (reqUnsigned),
      .req_address_i    (reqAddress),
      .req_store_data_i (reqStoreData),
      .ready_o          (readyO),
      .done_o           (doneO),
      .error_o          (errorO),
      .load_data_o      (loadDataO),
      .mem_address_o    (memAddress),
      .mem_write_data_o (memWriteData),
      .mem_write_o      (memWrite),
      .mem_read_o       (memRead),
      .mem_read_data_i  (memReadData)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Data memory: combinational read, clocked write. The bench preload port
   // is only used while the DUT is not writing.
   assign memReadData = mem[memAddress[7:2]];
   always @(posedge clk) begin
      if (memWrite) begin
         mem[memAddress[7:2]] <= memWriteData;
      end else if (tbWrEn) begin
         mem[tbWrIdx] <= tbWrData;
      end
   end

   // Reference load: shift the addressed lane down, mask, then extend.
   function automatic logic [31:0] modelLoad(input logic [31:0] word, input logic [1:0] sz,
                                             input logic uns, input logic [1:0] off);
      int unsigned sh;
      logic [31:0] v;
      sh = 8 * off;
      v  = word >> sh;
      if (sz == 2'b00) begin
         v = v & 32'h0000_00FF;
         if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'b01) begin
         v = v & 32'h0000_FFFF;
         if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end else begin
         v = word;
      end
      return v;
   endfunction

   // Reference store: clear the target lane of the old word and OR in data.
   function automatic logic [31:0] modelStore(input logic [31:0] word, input logic [31:0] data,
                                              input logic [1:0] sz, input logic [1:0] off);
      int unsigned sh;
      logic [31:0] mask;
      if (sz == 2'b10) return data;
      sh   = 8 * off;
      mask = (sz == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
      return (word & ~(mask << sh)) | ((data & mask) << sh);
   endfunction

   function automatic logic isMisaligned(input logic [1:0] sz, input logic [31:0] addr);
      return (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00);
   endfunction

   // Write one memory word through the preload port and mirror it into the
   // reference copy. Starts and ends on a falling edge.
   task automatic preloadWord(input int idx, input logic [31:0] data);
      tbWrEn   = 1'b1;
      tbWrIdx  = 6'(idx);
      tbWrData = data;
      refMem[idx] = data;
      @(negedge clk);
      tbWrEn = 1'b0;
   endtask

   // Issue one request and observe it until done_o, recording what the DUT
   // did along the way. lat counts cycles after the acceptance edge.
   task automatic applyStimulus(input logic wr, input logic [1:0] sz, input logic uns,
                                input logic [31:0] addr, input logic [31:0] data,
                                output int lat, output int nRd, output int nWr,
                                output logic [31:0] wrData, output logic [31:0] wrAddr,
                                output logic errSeen, output logic [31:0] ldData,
                                output logic bothSeen, output logic timedOut);
      int guard;
      lat = 0; nRd = 0; nWr = 0; wrData = '0; wrAddr = '0;
      errSeen = 1'b0; ldData = '0; bothSeen = 1'b0; timedOut = 1'b0;
      guard = 0;
      while (!readyO && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      if (!readyO) begin
         timedOut = 1'b1;
         return;
      end
      reqValid = 1'b1; reqWrite = wr; reqSize = sz; reqUnsigned = uns;
      reqAddress = addr; reqStoreData = data;
      @(posedge clk);
      @(negedge clk);
      reqValid = 1'b0;
      lat = 1;
      while (1) begin
         if (memRead) nRd++;
         if (memWrite) begin
            nWr++;
            wrData = memWriteData;
            wrAddr = memAddress;
         end
         if (memRead && memWrite) bothSeen = 1'b1;
         if (doneO) begin
            errSeen = errorO;
            ldData  = loadDataO;
            break;
         end
         if (lat >= 8) begin
            timedOut = 1'b1;
            break;
         end
         @(negedge clk);
         lat++;
      end
   endtask

   // Reset values are visible while reset is held; memory is preloaded
   // before release.
   task automatic test_reset();
      reset = 1'b1;
      reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'b00; reqUnsigned = 1'b0;
      reqAddress = '0; reqStoreData = '0;
      tbWrEn = 1'b0; tbWrIdx = '0; tbWrData = '0;
      @(negedge clk);
      assertCount++;
      if ({readyO, doneO, errorO, memRead, memWrite} !== 5'b10000) begin
         failCount++; $display("[TB] FAIL reset_ctrl: got %b expected %b", {readyO, doneO, errorO, memRead, memWrite}, 5'b10000);
      end
      assertCount++;
      if ({memAddress, memWriteData, loadDataO} !== 96'd0) begin
         failCount++; $display("[TB] FAIL reset_data: got %h %h %h expected zeros", memAddress, memWriteData, loadDataO);
      end
      for (int i = 0; i < 64; i++) preloadWord(i, $urandom);
      reset = 1'b0;
      expLoadData = '0;
      @(negedge clk);
   endtask

   task automatic test_directed_loads();
      int lat, nRd, nWr; logic [31:0] wrData, wrAddr, ld; logic err, both, to;
      preloadWord(4, 32'h8899_AABB);
      applyStimulus(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, lat, nRd, nWr, wrData, wrAddr, err, ld, both, to);
      assertCount++;
      if (to !== 1'b0 || lat !== 2) begin failCount++; $display("[TB] FAIL lb_latency: got %0d (timeout %b) expected 2", lat, to); end
      assertCount++;
      if (ld !== 32'hFFFF_FFAA) begin failCount++; $display("[TB] FAIL lb_data: got %h expected %h", ld, 32'hFFFF_FFAA); end
      assertCount++;
      if ({err, nRd[1:0], nWr[1:0]} !== 5'b0_01_00) begin failCount++; $display("[TB] FAIL lb_strobes: got err=%b rd=%0d wr=%0d expected 0 1 0", err, nRd, nWr); end
      applyStimulus(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, lat, nRd, nWr, wrData, wrAddr, err, ld, both, to);
      assertCount++;
      if (to !== 1'b0 || lat !== 2) begin failCount++; $display("[TB] FAIL lbu_latency: got %0d (timeout %b) expected 2", lat, to); end
      assertCount++;
      if (ld !== 32'h0000_00AA) begin failCount++; $display("[TB] FAIL lbu_data: got %h expected %h", ld, 32'h0000_00AA); end
      expLoadData = 32'h0000_00AA;
   endtask

   task automatic test_subword_store();
      int lat, nRd, nWr; logic [31:0] wrData, wrAddr, ld; logic err, both, to;
      applyStimulus(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_1234, lat, nRd, nWr, wrData, wrAddr, err, ld, both, to);
      assertCount++;
      if (to !== 1'b0 || lat !== 3) begin failCount++; $display("[TB] FAIL sh_latency: got %0d (timeout %b) expected 3", lat, to); end
      assertCount++;
      if (nRd !== 1 || nWr !== 1) begin failCount++; $display("[TB] FAIL sh_strobes: got rd=%0d wr=%0d expected 1 1", nRd, nWr); end
      assertCount++;
      if (wrData !== 32'h1234_AABB || wrAddr !== 32'h10) begin failCount++; $display("[TB] FAIL sh_write: got %h @%h expected 1234aabb @00000010", wrData, wrAddr); end
      assertCount++;
      if (mem[4] !== 32'h1234_AABB) begin failCount++; $display("[TB] FAIL sh_memory: got %h expected %h", mem[4], 32'h1234_AABB); end
      assertCount++;
      if (ld !== expLoadData) begin failCount++; $display("[TB] FAIL sh_load_hold: got %h expected %h", ld, expLoadData); end
      refMem[4] = 32'h1234_AABB;
   endtask

   task automatic test_word_store();
      int lat, nRd, nWr; logic [31:0] wrData, wrAddr, ld; logic err, both, to;
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF, lat, nRd, nWr, wrData, wrAddr, err, ld, both, to);
      assertCount++;
      if (to !== 1'b0 || lat !== 2) begin failCount++; $display("[TB] FAIL sw_latency: got %0d (timeout %b) expected 2", lat, to); end
      assertCount++;
      if (nRd !== 0 || nWr !== 1) begin failCount++; $display("[TB] FAIL sw_strobes: got rd=%0d wr=%0d expected 0 1", nRd, nWr); end
      assertCount++;
      if (wrData !== 32'hDEAD_BEEF || wrAddr !== 32'h20) begin failCount++; $display("[TB] FAIL sw_write: got %h @%h expected deadbeef @00000020", wrData, wrAddr); end
      refMem[8] = 32'hDEAD_BEEF;
   endtask

   task automatic test_misaligned();
      int lat, nRd, nWr; logic [31:0] wrData, wrAddr, ld; logic err, both, to;
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h22, 32'h0, lat, nRd, nWr, wrData, wrAddr, err, ld, both, to);
      assertCount++;
      if (to !== 1'b0 || lat !== 1 || err !== 1'b1) begin failCount++; $display("[TB] FAIL lw_misaligned: got lat=%0d err=%b expected 1 1", lat, err); end
      assertCount++;
      if (nRd !== 0 || nWr !== 0 || ld !== expLoadData) begin failCount++; $display("[TB] FAIL lw_misaligned_side: got rd=%0d wr=%0d ld=%h expected 0 0 %h", nRd, nWr, ld, expLoadData); end
      applyStimulus(1'b0, 2'b01, 1'b0, 32'h21, 32'h0, lat, nRd, nWr, wrData, wrAddr, err, ld, both, to);
      assertCount++;
      if (to !== 1'b0 || lat !== 1 || err !== 1'b1) begin failCount++; $display("[TB] FAIL lh_misaligned: got lat=%0d err=%b expected 1 1", lat, err); end
      assertCount++;
      if (nRd !== 0 || nWr !== 0 || ld !== expLoadData) begin failCount++; $display("[TB] FAIL lh_misaligned_side: got rd=%0d wr=%0d ld=%h expected 0 0 %h", nRd, nWr, ld, expLoadData); end
      applyStimulus(1'b1, 2'b11, 1'b0, 32'h0, 32'h5555_5555, lat, nRd, nWr, wrData, wrAddr, err, ld, both, to);
      assertCount++;
      if (lat !== 1 || err !== 1'b1 || nWr !== 0 || mem[0] !== refMem[0]) begin failCount++; $display("[TB] FAIL illegal_size: got lat=%0d err=%b wr=%0d mem=%h expected 1 1 0 %h", lat, err, nWr, mem[0], refMem[0]); end
   endtask

   // Valid stays high across two loads; the second must wait for the edge
   // after DONE, so done pulses appear at samples 2 and 5.
   task automatic test_back_to_back();
      int doneCount, firstDone, secondDone, readCount, guard;
      logic [31:0] firstData, secondData;
      doneCount = 0; firstDone = -1; secondDone = -1; readCount = 0;
      firstData = '0; secondData = '0;
      guard = 0;
      while (!readyO && guard < 10) begin @(negedge clk); guard++; end
      reqValid = 1'b1; reqWrite = 1'b0; reqSize = 2'b10; reqUnsigned = 1'b0;
      reqAddress = 32'h10; reqStoreData = '0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (memRead) readCount++;
         if (doneO) begin
            doneCount++;
            if (doneCount == 1) begin firstDone = i; firstData = loadDataO; end
            if (doneCount == 2) begin secondDone = i; secondData = loadDataO; end
         end
         if (i == 1) reqAddress = 32'h20;
         if (i == 4) reqValid = 1'b0;
      end
      assertCount++;
      if (firstDone !== 2 || secondDone !== 5) begin failCount++; $display("[TB] FAIL b2b_timing: got done at %0d,%0d expected 2,5", firstDone, secondDone); end
      assertCount++;
      if (doneCount !== 2 || readCount !== 2) begin failCount++; $display("[TB] FAIL b2b_count: got done=%0d reads=%0d expected 2 2", doneCount, readCount); end
      assertCount++;
      if (firstData !== refMem[4] || secondData !== refMem[8]) begin failCount++; $display("[TB] FAIL b2b_data: got %h %h expected %h %h", firstData, secondData, refMem[4], refMem[8]); end
      expLoadData = refMem[8];
   endtask

   // Reset lands asynchronously while the RMW write strobe is up.
   task automatic test_reset_mid_rmw();
      int guard, lateDone;
      preloadWord(12, 32'hCAFE_F00D);
      guard = 0;
      while (!readyO && guard < 10) begin @(negedge clk); guard++; end
      reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'b00; reqUnsigned = 1'b0;
      reqAddress = 32'h31; reqStoreData = 32'h0000_0055;
      @(negedge clk);
      reqValid = 1'b0;
      @(negedge clk);
      assertCount++;
      if (memWrite !== 1'b1) begin failCount++; $display("[TB] FAIL rmw_reach_write: got %b expected 1", memWrite); end
      #2 reset = 1'b1;
      #1;
      assertCount++;
      if ({memWrite, readyO, doneO} !== 3'b010) begin failCount++; $display("[TB] FAIL rmw_reset_async: got %b expected 010", {memWrite, readyO, doneO}); end
      assertCount++;
      if ({memWriteData, memAddress, loadDataO} !== 96'd0) begin failCount++; $display("[TB] FAIL rmw_reset_data: got %h %h %h expected zeros", memWriteData, memAddress, loadDataO); end
      @(negedge clk);
      reset = 1'b0;
      expLoadData = '0;
      lateDone = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (doneO) lateDone++;
      end
      assertCount++;
      if (mem[12] !== 32'hCAFE_F00D || lateDone !== 0 || readyO !== 1'b1) begin failCount++; $display("[TB] FAIL rmw_reset_abandon: got mem=%h done=%0d ready=%b expected cafef00d 0 1", mem[12], lateDone, readyO); end
   endtask

   task automatic test_random();
      int lat, nRd, nWr, expLat, expRd, expWr, idx;
      logic [31:0] wrData, wrAddr, ld, addr, data, expWrData, expLd;
      logic err, both, to, wr, uns, mis;
      logic [1:0] sz, off;
      for (int n = 0; n < 40; n++) begin
         wr = 1'($urandom_range(0, 1)); uns = 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 3)); data = $urandom;
         addr = 32'($urandom_range(0, 255));
         if ($urandom_range(0, 1) == 1) begin
            if (sz == 2'b01) addr[0] = 1'b0;
            if (sz == 2'b10) addr[1:0] = 2'b00;
         end
         idx = int'(addr[7:2]); off = addr[1:0];
         mis = isMisaligned(sz, addr);
         expLat    = mis ? 1 : (!wr ? 2 : (sz == 2'b10 ? 2 : 3));
         expRd     = mis ? 0 : ((!wr || sz != 2'b10) ? 1 : 0);
         expWr     = (mis || !wr) ? 0 : 1;
         expWrData = modelStore(refMem[idx], data, sz, off);
         expLd     = (!mis && !wr) ? modelLoad(refMem[idx], sz, uns, off) : expLoadData;
         applyStimulus(wr, sz, uns, addr, data, lat, nRd, nWr, wrData, wrAddr, err, ld, both, to);
         assertCount++;
         if (to !== 1'b0 || lat !== expLat) begin failCount++; $display("[TB] FAIL rnd%0d_latency: got %0d (timeout %b) expected %0d", n, lat, to, expLat); end
         assertCount++;
         if (err !== mis || nRd !== expRd || nWr !== expWr || both !== 1'b0) begin
            failCount++; $display("[TB] FAIL rnd%0d_strobes: got err=%b rd=%0d wr=%0d both=%b expected %b %0d %0d 0", n, err, nRd, nWr, both, mis, expRd, expWr);
         end
         assertCount++;
         if (ld !== expLd) begin failCount++; $display("[TB] FAIL rnd%0d_load: got %h expected %h", n, ld, expLd); end
         if (expWr == 1) begin
            assertCount++;
            if (wrData !== expWrData || wrAddr !== {addr[31:2], 2'b00}) begin
               failCount++; $display("[TB] FAIL rnd%0d_write: got %h @%h expected %h @%h", n, wrData, wrAddr, expWrData, {addr[31:2], 2'b00});
            end
            refMem[idx] = expWrData;
         end
         assertCount++;
         if (mem[idx] !== refMem[idx]) begin failCount++; $display("[TB] FAIL rnd%0d_memory: got %h expected %h", n, mem[idx], refMem[idx]); end
         expLoadData = expLd;
      end
   endtask

   // Scenario sequence and summary.
   initial begin
      test_reset();
      test_directed_loads();
      test_subword_store();
      test_word_store();
      test_misaligned();
      test_back_to_back();
      test_reset_mid_rmw();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   // Hard stop in case a scenario stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: data/address width (only 32 is supported).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port req_valid_i, input, 1 bit: request present from the pipeline.
REQ-005 The block SHALL have port req_write_i, input, 1 bit: 1 = store, 0 = load.
REQ-006 The block SHALL have port req_size_i, input, 2 bits: 00 = byte, 01 = halfword, 10 = word, 11 = illegal.
REQ-007 The block SHALL have port req_unsigned_i, input, 1 bit: 1 = zero-extend loads, 0 = sign-extend loads.
REQ-008 The block SHALL have port req_address_i, input, 32 bits: byte address.
REQ-009 The block SHALL have port req_store_data_i, input, 32 bits: store data, with sub-word data in the low bits.
REQ-010 The block SHALL have port ready_o, output, 1 bit: high only in IDLE.
REQ-011 The block SHALL have port done_o, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port error_o, output, 1 bit: one-cycle pulse, coincident with done_o, for a misaligned or illegal request.
REQ-013 The block SHALL have port load_data_o, output, 32 bits: extended load result.
REQ-014 The block SHALL have port mem_address_o, output, 32 bits: word-aligned address to the data memory.
REQ-015 The block SHALL have port mem_write_data_o, output, 32 bits: word written to the data memory.
REQ-016 The block SHALL have ports mem_write_o and mem_read_o, output, 1 bit each: data-memory strobes.
REQ-017 The block SHALL have port mem_read_data_i, input, 32 bits: combinational read data from the data memory.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, WRITE, RMW_READ, RMW_WRITE, DONE.
REQ-019 A request SHALL be accepted on a clk edge in IDLE with req_valid_i=1; in all other states req_valid_i SHALL be ignored.
REQ-020 On acceptance, the block SHALL register write, size, unsigned, address[1:0], store data and mem_address_o = {address[31:2],2'b00}.
REQ-021 A request SHALL be misaligned if size=01 with addr[0]=1, size=10 with addr[1:0]!=00, or size=11.
REQ-022 A misaligned request SHALL go IDLE->DONE with error_o=1 and no memory strobe, leaving load_data_o unchanged.
REQ-023 Transitions: aligned load IDLE->LOAD->DONE; word store IDLE->WRITE->DONE; byte/halfword store IDLE->RMW_READ->RMW_WRITE->DONE; DONE->IDLE unconditionally.
REQ-024 mem_read_o SHALL be 1 only in LOAD and RMW_READ, and mem_write_o SHALL be 1 only in WRITE and RMW_WRITE; both are decoded from the state register and are never high together.
REQ-025 Byte lanes SHALL be little-endian: byte n occupies bits [8n+7:8n] and halfword addr[1]=h occupies bits [16h+15:16h].
REQ-026 In LOAD, the selected lane of mem_read_data_i SHALL be extended to 32 bits (sign or zero per unsigned) and registered into load_data_o at the LOAD->DONE edge; a word load SHALL pass the data unchanged.
REQ-027 load_data_o SHALL hold its value until the next successful load.
REQ-028 In RMW_READ, mem_read_data_i SHALL be registered into a merge register.
REQ-029 In RMW_WRITE, mem_write_data_o SHALL be the merge register with only the addressed lane replaced by the low 8 or 16 bits of the store data.
REQ-030 In WRITE, mem_write_data_o SHALL be the registered store data; in all other states it SHALL be 0.
REQ-031 done_o SHALL be 1 exactly in DONE; latency from acceptance edge to done_o SHALL be 2 cycles for load and word store, 3 cycles for sub-word store, and 1 cycle for error.
REQ-032 The earliest next acceptance SHALL be the edge after DONE, giving back-to-back throughput of one op per 3 (or 4) cycles.

Reset
REQ-033 Reset assertion SHALL immediately force IDLE, ready_o=1, and done_o, error_o, mem_read_o, mem_write_o, mem_write_data_o, mem_address_o, load_data_o and the merge register to 0.
REQ-034 Reset asserted in any state, including RMW_WRITE before the edge, SHALL abandon the operation with no memory write and no done_o pulse.

Verification
REQ-035 Bench: memory word 0x10 = 0x8899AABB; lb at addr 0x11 -> load_data_o=0xFFFFFFAA with done_o 2 cycles after acceptance; lbu at the same address -> 0x000000AA.
REQ-036 Bench: with the same word, sh 0x1234 at addr 0x12 -> one mem_read_o cycle, then one mem_write_o cycle with data 0x1234AABB; done_o 3 cycles after acceptance.
REQ-037 Bench: sw 0xDEADBEEF at addr 0x20 -> a single mem_write_o cycle, address 0x20, data 0xDEADBEEF; no mem_read_o.
REQ-038 Bench: lw at addr 0x22 and lh at addr 0x21 -> each gives error_o=done_o=1 one cycle after acceptance, no strobes, and load_data_o unchanged.
REQ-039 Bench: reset asserted mid-RMW_WRITE -> mem_write_o drops immediately, memory word unchanged, block in IDLE with ready_o=1.
REQ-040 Bench: req_valid_i held high continuously for two loads -> second load accepted only on the edge after DONE; each request completes exactly once.
